// File: rtl/fault_effect_monitor_pkg.sv
// ============================================================================
//  Package     : fault_mon_pkg
//  Description : Shared FSM encodings and injection classification codes
//                for the fault-effect monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fault_mon_pkg;

    // Campaign FSM encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

    // Per-injection classification
    localparam logic CLS_MASKED = 1'b0;
    localparam logic CLS_PROP   = 1'b1;

    // Any differing output bit means the fault reached the outputs
    function automatic logic classify(input logic i_any_mis);
        return i_any_mis ? CLS_PROP : CLS_MASKED;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fault_effect_monitor_if.sv
// ============================================================================
//  Interface   : fault_effect_monitor_if
//  Description : Injection-result inputs and campaign statistics outputs of
//                the fault-effect monitor. master = injection driver,
//                slave = monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fault_effect_monitor_if #(
    parameter int OUT_W = 2,
    parameter int CNT_W = 32
) ();

    logic             start;
    logic             inj_valid;
    logic [OUT_W-1:0] gd_out;
    logic [OUT_W-1:0] fl_out;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] smp_gd;
    logic [OUT_W-1:0] smp_fl;
    logic             err_flag;
    logic [OUT_W-1:0] err_mask;
    logic [CNT_W-1:0] inj_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] masked_cnt;
    logic [CNT_W-1:0] first_err;

    modport master (
        output start, inj_valid, gd_out, fl_out,
        input  busy, done, smp_gd, smp_fl, err_flag, err_mask,
               inj_cnt, err_cnt, masked_cnt, first_err
    );

    modport slave (
        input  start, inj_valid, gd_out, fl_out,
        output busy, done, smp_gd, smp_fl, err_flag, err_mask,
               inj_cnt, err_cnt, masked_cnt, first_err
    );

endinterface

`default_nettype wire

// File: rtl/fault_cmp.sv
// ============================================================================
//  Module      : fault_cmp
//  Description : Edge sampler and XOR comparator for golden/faulty outputs.
//                Sampled values and the error flag are cleared on every edge
//                that does not sample, so only values present at a sampling
//                edge are ever reported.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fault_cmp #(
    parameter int OUT_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_sample,
    input  wire logic [OUT_W-1:0] i_gd,
    input  wire logic [OUT_W-1:0] i_fl,
    output logic      [OUT_W-1:0] o_mis,
    output logic      [OUT_W-1:0] o_smp_gd,
    output logic      [OUT_W-1:0] o_smp_fl,
    output logic                  o_err_flag
);

    logic [OUT_W-1:0] r_smp_gd;
    logic [OUT_W-1:0] r_smp_fl;
    logic             r_err_flag;
    logic [OUT_W-1:0] w_mis;

    assign w_mis = i_gd ^ i_fl;

    // Capture on sampling edges, otherwise return to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp_gd   <= '0;
            r_smp_fl   <= '0;
            r_err_flag <= 1'b0;
        end else if (i_sample) begin
            r_smp_gd   <= i_gd;
            r_smp_fl   <= i_fl;
            r_err_flag <= |w_mis;
        end else begin
            r_smp_gd   <= '0;
            r_smp_fl   <= '0;
            r_err_flag <= 1'b0;
        end
    end

    assign o_mis      = w_mis;
    assign o_smp_gd   = r_smp_gd;
    assign o_smp_fl   = r_smp_fl;
    assign o_err_flag = r_err_flag;

endmodule

`default_nettype wire

// File: rtl/fault_effect_monitor.sv
// ============================================================================
//  Module      : fault_effect_monitor
//  Description : Classifies each fault injection as propagated or masked and
//                accumulates campaign statistics. Holds the campaign FSM and
//                counters; sampling/comparison lives in fault_cmp.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fault_effect_monitor
    import fault_mon_pkg::*;
#(
    parameter int OUT_W = 2,
    parameter int CNT_W = 32,
    parameter int N_INJ = 10000
) (
    input  wire logic clk,
    input  wire logic rst,
    fault_effect_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(N_INJ - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [OUT_W-1:0] r_err_mask;
    logic [CNT_W-1:0] r_inj_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_masked_cnt;
    logic [CNT_W-1:0] r_first_err;

    logic             w_sample;
    logic             w_start;
    logic             w_cls;
    logic [OUT_W-1:0] w_mis;

    // start is only honoured outside RUN; samples are only taken inside RUN,
    // so inj_valid on the start cycle is never counted
    assign w_start  = (r_state != ST_RUN) && bus.start;
    assign w_sample = (r_state == ST_RUN) && bus.inj_valid;
    assign w_cls    = classify(|w_mis);

    fault_cmp #(.OUT_W(OUT_W)) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .i_sample   (w_sample),
        .i_gd       (bus.gd_out),
        .i_fl       (bus.fl_out),
        .o_mis      (w_mis),
        .o_smp_gd   (bus.smp_gd),
        .o_smp_fl   (bus.smp_fl),
        .o_err_flag (bus.err_flag)
    );

    // Campaign FSM with statistics counters and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err_mask   <= '0;
            r_inj_cnt    <= '0;
            r_err_cnt    <= '0;
            r_masked_cnt <= '0;
            r_first_err  <= '0;
        end else if (w_start) begin
            r_state      <= ST_RUN;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err_mask   <= '0;
            r_inj_cnt    <= '0;
            r_err_cnt    <= '0;
            r_masked_cnt <= '0;
            r_first_err  <= '0;
        end else if (w_sample) begin
            r_inj_cnt <= r_inj_cnt + 1'b1;
            if (w_cls == CLS_PROP) begin
                r_err_cnt  <= r_err_cnt + 1'b1;
                r_err_mask <= r_err_mask | w_mis;
                if (r_err_cnt == '0) begin
                    r_first_err <= r_inj_cnt;
                end
            end else begin
                r_masked_cnt <= r_masked_cnt + 1'b1;
            end
            // The final sample of the campaign closes it on the same edge
            if (r_inj_cnt == C_LAST_IDX) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err_mask   = r_err_mask;
    assign bus.inj_cnt    = r_inj_cnt;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.masked_cnt = r_masked_cnt;
    assign bus.first_err  = r_first_err;

endmodule

`default_nettype wire

// File: tb/tb_fault_effect_monitor.sv
// ============================================================================
//  Testbench   : tb_fault_effect_monitor
//  Description : Directed scenarios plus randomized campaigns for the
//                fault-effect monitor, checked against a queue-based model of
//                the injections recorded in the current campaign.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fault_effect_monitor;

    localparam int OUT_W = 2;
    localparam int CNT_W = 32;
    localparam int N_INJ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fault_effect_monitor_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    fault_effect_monitor #(.OUT_W(OUT_W), .CNT_W(CNT_W), .N_INJ(N_INJ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Every output concatenated, for all-zero checks
    wire [4*CNT_W+4*OUT_W+2:0] w_all_out = {bus.busy, bus.done, bus.smp_gd, bus.smp_fl,
        bus.err_flag, bus.err_mask, bus.inj_cnt, bus.err_cnt, bus.masked_cnt, bus.first_err};

    // ---------------- reference model ----------------
    // The campaign is the list of (golden, faulty) pairs recorded so far.
    logic [1:0] q_gd[$];
    logic [1:0] q_fl[$];
    bit         m_run;
    bit         m_done;
    logic [1:0] m_sgd;
    logic [1:0] m_sfl;
    logic       m_flag;

    function automatic int m_errs();
        int n = 0;
        foreach (q_gd[i]) if (q_gd[i] != q_fl[i]) n++;
        return n;
    endfunction

    function automatic logic [1:0] m_mask();
        logic [1:0] m = 2'b00;
        foreach (q_gd[i]) m = m | (q_gd[i] ^ q_fl[i]);
        return m;
    endfunction

    function automatic int m_first();
        foreach (q_gd[i]) if (q_gd[i] != q_fl[i]) return i;
        return 0;
    endfunction

    task automatic model_clear();
        q_gd.delete();
        q_fl.delete();
        m_run  = 0;
        m_done = 0;
        m_sgd  = 2'b00;
        m_sfl  = 2'b00;
        m_flag = 1'b0;
    endtask

    // One clock cycle of stimulus; model updated, outputs then sampled at +1
    task automatic cyc(input bit s, input bit v, input logic [1:0] g, input logic [1:0] f);
        bus.start     = s;
        bus.inj_valid = v;
        bus.gd_out    = g;
        bus.fl_out    = f;
        if (m_run && v) begin
            q_gd.push_back(g);
            q_fl.push_back(f);
            m_sgd  = g;
            m_sfl  = f;
            m_flag = (g != f);
            if (q_gd.size() == N_INJ) begin
                m_run  = 0;
                m_done = 1;
            end
        end else begin
            m_sgd  = 2'b00;
            m_sfl  = 2'b00;
            m_flag = 1'b0;
            if (!m_run && s) begin
                q_gd.delete();
                q_fl.delete();
                m_run  = 1;
                m_done = 0;
            end
        end
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.inj_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        model_clear();
        #2;
        checks++;
        if (w_all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", w_all_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 1, 2'b01, 2'b10);
        checks++;
        if (bus.inj_cnt !== 32'd0 || bus.busy !== 1'b0 || bus.smp_gd !== 2'b00) begin
            errors++;
            $display("FAIL idle_ignores_valid got inj=%0d busy=%b smp_gd=%b exp 0 0 00",
                     bus.inj_cnt, bus.busy, bus.smp_gd);
        end
    endtask

    task automatic test_all_masked();
        logic [1:0] pat [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        cyc(1, 0, 2'b00, 2'b00);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.inj_cnt !== 32'd0) begin
            errors++;
            $display("FAIL start_state got busy=%b done=%b inj=%0d exp 1 0 0",
                     bus.busy, bus.done, bus.inj_cnt);
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, pat[i], pat[i]);
        checks++;
        if (bus.masked_cnt !== 32'd4 || bus.err_cnt !== 32'd0 || bus.err_mask !== 2'b00 ||
            bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.inj_cnt !== 32'd4) begin
            errors++;
            $display("FAIL all_masked got masked=%0d err=%0d mask=%b done=%b busy=%b inj=%0d exp 4 0 00 1 0 4",
                     bus.masked_cnt, bus.err_cnt, bus.err_mask, bus.done, bus.busy, bus.inj_cnt);
        end
    endtask

    task automatic test_mixed();
        logic [1:0] gd [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [1:0] fl [4] = '{2'b01, 2'b11, 2'b11, 2'b10};
        logic       fl_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        cyc(1, 0, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, gd[i], fl[i]);
            checks++;
            if (bus.err_flag !== fl_exp[i]) begin
                errors++;
                $display("FAIL mixed_err_flag[%0d] got %b exp %b", i, bus.err_flag, fl_exp[i]);
            end
        end
        checks++;
        if (bus.err_cnt !== 32'd2 || bus.masked_cnt !== 32'd2 || bus.err_mask !== 2'b11 ||
            bus.first_err !== 32'd1 || bus.smp_gd !== 2'b00 || bus.smp_fl !== 2'b10) begin
            errors++;
            $display("FAIL mixed_stats got err=%0d masked=%0d mask=%b first=%0d smp=%b/%b exp 2 2 11 1 00/10",
                     bus.err_cnt, bus.masked_cnt, bus.err_mask, bus.first_err, bus.smp_gd, bus.smp_fl);
        end
    endtask

    task automatic test_gap();
        cyc(1, 0, 2'b00, 2'b00);
        cyc(0, 1, 2'b01, 2'b00);
        checks++;
        if (bus.smp_gd !== 2'b01 || bus.smp_fl !== 2'b00 || bus.err_flag !== 1'b1) begin
            errors++;
            $display("FAIL gap_first got %b/%b flag=%b exp 01/00 1", bus.smp_gd, bus.smp_fl, bus.err_flag);
        end
        cyc(0, 0, 2'b11, 2'b01);
        checks++;
        if (bus.smp_gd !== 2'b00 || bus.smp_fl !== 2'b00 || bus.err_flag !== 1'b0) begin
            errors++;
            $display("FAIL gap_cleared got %b/%b flag=%b exp 00/00 0", bus.smp_gd, bus.smp_fl, bus.err_flag);
        end
        cyc(0, 1, 2'b10, 2'b10);
        checks++;
        if (bus.smp_gd !== 2'b10 || bus.smp_fl !== 2'b10 || bus.err_flag !== 1'b0 ||
            bus.inj_cnt !== 32'd2) begin
            errors++;
            $display("FAIL gap_second got %b/%b flag=%b inj=%0d exp 10/10 0 2",
                     bus.smp_gd, bus.smp_fl, bus.err_flag, bus.inj_cnt);
        end
        // start while running is ignored; the sample on that edge still counts
        cyc(1, 1, 2'b01, 2'b10);
        checks++;
        if (bus.inj_cnt !== 32'd3 || bus.err_cnt !== 32'd2 || bus.first_err !== 32'd0) begin
            errors++;
            $display("FAIL start_in_run got inj=%0d err=%0d first=%0d exp 3 2 0",
                     bus.inj_cnt, bus.err_cnt, bus.first_err);
        end
    endtask

    task automatic test_start_with_valid();
        rst = 1'b1;
        model_clear();
        #2;
        rst = 1'b0;
        cyc(1, 1, 2'b11, 2'b00);
        checks++;
        if (bus.inj_cnt !== 32'd0 || bus.busy !== 1'b1 || bus.smp_gd !== 2'b00 ||
            bus.err_flag !== 1'b0 || bus.err_cnt !== 32'd0) begin
            errors++;
            $display("FAIL start_with_valid got inj=%0d busy=%b smp_gd=%b flag=%b err=%0d exp 0 1 00 0 0",
                     bus.inj_cnt, bus.busy, bus.smp_gd, bus.err_flag, bus.err_cnt);
        end
    endtask

    task automatic test_after_done();
        cyc(0, 1, 2'b00, 2'b00);
        cyc(0, 1, 2'b11, 2'b10);
        cyc(0, 1, 2'b00, 2'b00);
        cyc(0, 1, 2'b10, 2'b00);
        checks++;
        if (bus.done !== 1'b1 || bus.inj_cnt !== 32'd4 || bus.err_cnt !== 32'd2 ||
            bus.first_err !== 32'd1 || bus.err_mask !== 2'b11) begin
            errors++;
            $display("FAIL done_stats got done=%b inj=%0d err=%0d first=%0d mask=%b exp 1 4 2 1 11",
                     bus.done, bus.inj_cnt, bus.err_cnt, bus.first_err, bus.err_mask);
        end
        cyc(0, 1, 2'b11, 2'b00);
        cyc(0, 1, 2'b01, 2'b10);
        checks++;
        if (bus.done !== 1'b1 || bus.inj_cnt !== 32'd4 || bus.err_cnt !== 32'd2 ||
            bus.masked_cnt !== 32'd2 || bus.err_mask !== 2'b11) begin
            errors++;
            $display("FAIL done_frozen got done=%b inj=%0d err=%0d masked=%0d mask=%b exp 1 4 2 2 11",
                     bus.done, bus.inj_cnt, bus.err_cnt, bus.masked_cnt, bus.err_mask);
        end
        cyc(1, 0, 2'b00, 2'b00);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.inj_cnt !== 32'd0 ||
            bus.err_cnt !== 32'd0 || bus.masked_cnt !== 32'd0 || bus.err_mask !== 2'b00 ||
            bus.first_err !== 32'd0) begin
            errors++;
            $display("FAIL restart_clear got done=%b busy=%b inj=%0d err=%0d masked=%0d mask=%b first=%0d exp 0 1 0 0 0 00 0",
                     bus.done, bus.busy, bus.inj_cnt, bus.err_cnt, bus.masked_cnt, bus.err_mask, bus.first_err);
        end
        for (int i = 0; i < 3; i++) cyc(0, 1, 2'b00, 2'b00);
        cyc(0, 1, 2'b00, 2'b01);
        checks++;
        if (bus.done !== 1'b1 || bus.err_cnt !== 32'd1 || bus.first_err !== 32'd3 ||
            bus.err_mask !== 2'b01) begin
            errors++;
            $display("FAIL rerun got done=%b err=%0d first=%0d mask=%b exp 1 1 3 01",
                     bus.done, bus.err_cnt, bus.first_err, bus.err_mask);
        end
    endtask

    task automatic test_mid_reset();
        cyc(1, 0, 2'b00, 2'b00);
        cyc(0, 1, 2'b01, 2'b11);
        cyc(0, 1, 2'b10, 2'b10);
        #3;
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (w_all_out !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %h exp 0", w_all_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 1, 2'b11, 2'b00);
        checks++;
        if (bus.busy !== 1'b0 || bus.inj_cnt !== 32'd0 || bus.err_flag !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle got busy=%b inj=%0d flag=%b exp 0 0 0",
                     bus.busy, bus.inj_cnt, bus.err_flag);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            checks++;
            if (bus.smp_gd !== m_sgd || bus.smp_fl !== m_sfl || bus.err_flag !== m_flag) begin
                errors++;
                $display("FAIL rnd_sample[%0d] got %b/%b flag=%b exp %b/%b flag=%b",
                         n, bus.smp_gd, bus.smp_fl, bus.err_flag, m_sgd, m_sfl, m_flag);
            end
            checks++;
            if (bus.inj_cnt !== 32'(q_gd.size()) || bus.err_cnt !== 32'(m_errs()) ||
                bus.masked_cnt !== 32'(q_gd.size() - m_errs())) begin
                errors++;
                $display("FAIL rnd_counts[%0d] got inj=%0d err=%0d masked=%0d exp %0d %0d %0d",
                         n, bus.inj_cnt, bus.err_cnt, bus.masked_cnt,
                         q_gd.size(), m_errs(), q_gd.size() - m_errs());
            end
            checks++;
            if (bus.err_mask !== m_mask() || bus.busy !== m_run || bus.done !== m_done) begin
                errors++;
                $display("FAIL rnd_status[%0d] got mask=%b busy=%b done=%b exp %b %b %b",
                         n, bus.err_mask, bus.busy, bus.done, m_mask(), m_run, m_done);
            end
            if (m_errs() != 0) begin
                checks++;
                if (bus.first_err !== 32'(m_first())) begin
                    errors++;
                    $display("FAIL rnd_first_err[%0d] got %0d exp %0d", n, bus.first_err, m_first());
                end
            end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.inj_valid = 1'b0;
        bus.gd_out    = 2'b00;
        bus.fl_out    = 2'b00;
        test_reset();
        test_all_masked();
        test_mixed();
        test_gap();
        test_start_with_valid();
        test_after_done();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
